seg7_scan_driver: RTL and testbench

- Downstream consumer of the 32-bit `data_o` word produced by the lab logic block.
- Renders that word as 8 hexadecimal digits on a common-anode, time-multiplexed 7-segment display.
- Snapshots its inputs once per frame so the displayed digits never tear.
- Inserts an all-anodes-off gap at every digit switch to suppress ghosting.

---
 rtl/seg7_scan_driver.sv | 124 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode hex display.
// Inputs are snapshotted once per frame; each digit slot starts with an all-dark gap.
module seg7_scan_driver #(
  parameter int unsigned DIGIT_PERIOD = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  blank_i,
  input  logic [7:0]  dp_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int unsigned CntW = $clog2(DIGIT_PERIOD);
  localparam logic [CntW-1:0] CntMax   = CntW'(DIGIT_PERIOD - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     data_q, data_d;
  logic [7:0]      blank_q, blank_d;
  logic [7:0]      dp_q, dp_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_out_q, dp_out_d;
  logic            frame_q, frame_d;

  logic            frame_start;
  logic            slot_dark;
  logic [3:0]      nibble;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    blank_d     = blank_q;
    dp_d        = dp_q;
    an_d        = 8'hFF;
    seg_d       = 7'h7F;
    dp_out_d    = 1'b1;
    frame_d     = 1'b0;
    frame_start = (cnt_q == '0) && (idx_q == 3'd0);
    nibble      = data_q[{idx_q, 2'b00} +: 4];
    slot_dark   = (cnt_q < BlankEnd) || blank_q[idx_q];

    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (frame_start) begin
      data_d  = data_i;
      blank_d = blank_i;
      dp_d    = dp_i;
      frame_d = 1'b1;
    end

    // Outputs follow the pre-edge slot and snapshot, giving one cycle of latency.
    if (!slot_dark) begin
      an_d     = ~(8'b1 << idx_q);
      seg_d    = hex_font(nibble);
      dp_out_d = ~dp_q[idx_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      data_q   <= 32'h0;
      blank_q  <= 8'h0;
      dp_q     <= 8'h0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_out_q <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      blank_q  <= blank_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      frame_q  <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_out_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: vector table, corner sequences and
// randomized inputs against a frame/slot arithmetic model.
module tb_seg7_scan_driver;

  localparam int DP    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * DP;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [7:0]  blank;
  logic [7:0]  dpi;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  seg7_scan_driver #(
    .DIGIT_PERIOD(DP),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .data_i (data),
    .blank_i(blank),
    .dp_i   (dpi),
    .an_o   (an_o),
    .seg_o  (seg_o),
    .dp_o   (dp_o),
    .frame_o(frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model state: edges since reset release and the frame's captured inputs.
  int          n = 0;
  logic [31:0] s_data;
  logic [7:0]  s_blank;
  logic [7:0]  s_dp;
  logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  p;
    int          slot;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at n=%0d: got %h, want %h", name, n, act, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fr;
    int p, slot, off;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
    if (rst_n && n > 0) begin
      p    = n - 1;
      slot = (p / DP) % 8;
      off  = p % DP;
      e_fr = ((p % FRAME) == 0);
      if (off >= BC && !s_blank[slot]) begin
        e_an  = ~(8'h01 << slot);
        e_seg = font[(s_data >> (4 * slot)) & 32'hF];
        e_dp  = ~s_dp[slot];
      end
    end
    chk("model_an", {24'h0, an_o}, {24'h0, e_an});
    chk("model_seg", {25'h0, seg_o}, {25'h0, e_seg});
    chk("model_dp", {31'h0, dp_o}, {31'h0, e_dp});
    chk("model_frame", {31'h0, frame_o}, {31'h0, e_fr});
    chk("one_anode", {31'h0, ($countones(~an_o) <= 1)}, 32'h1);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      n++;
      if (((n - 1) % FRAME) == 0) begin
        s_data  = data;
        s_blank = blank;
        s_dp    = dpi;
      end
    end
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
    rst_n = 1'b0;
    #1;
    chk("rst_an", {24'h0, an_o}, 32'hFF);
    chk("rst_seg", {25'h0, seg_o}, 32'h7F);
    data  = d;
    blank = b;
    dpi   = p;
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  initial begin
    int fcount;
    rst_n = 1'b0;
    data  = 32'h89ABCDEF;
    blank = 8'h00;
    dpi   = 8'h00;

    vecs[0] = '{32'h89ABCDEF, 8'h00, 8'h00, 0, 8'hFE, 7'h0E, 1'b1};
    vecs[1] = '{32'h89ABCDEF, 8'h00, 8'h00, 1, 8'hFD, 7'h06, 1'b1};
    vecs[2] = '{32'h89ABCDEF, 8'h00, 8'h00, 7, 8'h7F, 7'h00, 1'b1};
    vecs[3] = '{32'h01234567, 8'h0F, 8'h81, 0, 8'hFF, 7'h7F, 1'b1};
    vecs[4] = '{32'h01234567, 8'h0F, 8'h81, 4, 8'hEF, 7'h30, 1'b1};
    vecs[5] = '{32'h01234567, 8'h0F, 8'h81, 7, 8'h7F, 7'h40, 1'b0};

    // Reset hold, then release and count frame pulses over three frames.
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    rst_n  = 1'b1;
    n      = 0;
    fcount = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_o) fcount++;
    end
    chk("frame_count_3", fcount, 3);

    // Vector table: each entry lands on the first lit cycle of its slot.
    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].d, vecs[v].b, vecs[v].p);
      run_to(vecs[v].slot * DP + BC + 1);
      chk($sformatf("vec%0d_an", v), {24'h0, an_o}, {24'h0, vecs[v].an});
      chk($sformatf("vec%0d_seg", v), {25'h0, seg_o}, {25'h0, vecs[v].seg});
      chk($sformatf("vec%0d_dp", v), {31'h0, dp_o}, {31'h0, vecs[v].dpo});
    end

    // Tear: new data mid-frame must wait for the next frame start.
    do_reset(32'h0, 8'h00, 8'h00);
    run_to(3 * DP + 1);
    data = 32'h11111111;
    run_to(5 * DP + BC + 1);
    chk("tear_same_frame", {25'h0, seg_o}, 32'h40);
    run_to(FRAME + 5 * DP + BC + 1);
    chk("tear_next_frame", {25'h0, seg_o}, 32'h79);

    // Asynchronous reset mid-slot at digit 5.
    do_reset(32'h89ABCDEF, 8'h00, 8'h00);
    run_to(5 * DP + 4 + 1);
    chk("pre_async_an", {24'h0, an_o}, 32'hDF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", {24'h0, an_o}, 32'hFF);
    chk("async_seg", {25'h0, seg_o}, 32'h7F);
    chk("async_frame", {31'h0, frame_o}, 32'h0);
    data = 32'h00000007;
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    run_to(BC + 1);
    chk("restart_an", {24'h0, an_o}, 32'hFE);
    chk("restart_seg", {25'h0, seg_o}, 32'h78);

    // Randomized inputs across three frames.
    do_reset($urandom, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 3 * FRAME + 5; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        data  = $urandom;
        blank = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
        dpi   = 8'($urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
